jogo_memoria_param: RTL and testbench
=====================================

// Module: jogo_memoria_param
// PURPOSE
//   Parametrised memory-game core: control unit, datapath and play detector in one block.
//   Compares each player move on `chaves` against an internal sequence, advancing one address per correct move.
//   Ends in a hit, miss or (optional) timeout.
//   Raw debug buses feed external hexa7seg decoders at board top level.
// PARAMETERS
//   N_CHAVES        4     width of chaves/leds/sequence words (>=2)
//   PROFUNDIDADE    16    sequence length, moves per round (>=2); ADDR_W = $clog2(PROFUNDIDADE)
//   TIMEOUT_CICLOS  5000  max clock cycles waiting for one move (only with JOGO_TIMEOUT_EN)
// PORTS
//   clock          in   1         system clock, rising edge
//   reset          in   1         asynchronous, active-high
//   iniciar        in   1         level; starts/restarts a round
//   chaves         in   N_CHAVES  player switches; a move is exactly one switch high
//   acertou        out  1         round completed correctly
//   errou          out  1         wrong move
//   timeout        out  1         move not made in time (0 when macro off)
//   pronto         out  1         round finished, any cause
//   leds           out  N_CHAVES  registered last move (= db_jogada)
//   db_igual       out  1         registered move == memory word at current address
//   db_tem_jogada  out  1         one-cycle move-detected pulse
//   db_contagem    out  ADDR_W    current sequence address
//   db_memoria     out  N_CHAVES  memory word at current address
//   db_jogada      out  N_CHAVES  registered move
//   db_estado      out  4         FSM state code
// BEHAVIOUR
//   Reset (async): state INICIAL, address 0, move register 0, detector history 0, timeout counter 0.
//     All outputs 0 except db_memoria = word(0).
//   Sequence ROM (combinational): word(a) = 1 << (a mod N_CHAVES).
//   Move detection: chaves_ant <= chaves every cycle; db_tem_jogada = (chaves!=0) && (chaves_ant==0).
//     One pulse per 0->nonzero transition; held switches never retrigger.
//     The move must be held >=2 cycles.
//   FSM (Moore; outputs decoded from state register), codes in hex:
//     INICIAL 0    : iniciar -> PREPARACAO
//     PREPARACAO 1 : clear address, move register, timeout counter -> ESPERA
//     ESPERA 2     : db_tem_jogada -> REGISTRA
//                    else timeout counter==TIMEOUT_CICLOS-1 -> FIM_TIMEOUT
//                    The move has priority if both occur in the same cycle.
//     REGISTRA 4   : move register <= chaves -> COMPARA
//     COMPARA 5    : !db_igual -> FIM_ERRO
//                    else address==PROFUNDIDADE-1 -> FIM_ACERTO
//                    else -> PROXIMO
//     PROXIMO 6    : address+1; clear timeout counter -> ESPERA
//     FIM_ACERTO A : acertou=1, pronto=1
//     FIM_ERRO E   : errou=1, pronto=1
//     FIM_TIMEOUT D: timeout=1, pronto=1
//     Any FIM state: iniciar -> PREPARACAO. Outputs clear on leaving.
//     Unused codes -> INICIAL.
//   Latency: move pulse at cycle t -> REGISTRA t+1 -> COMPARA t+2 -> result state/outputs at t+3.
//   Address never wraps: the final move ends the round, so address stays at PROFUNDIDADE-1 in FIM_ACERTO.
//   iniciar is ignored outside INICIAL/FIM states. Reset mid-round aborts to INICIAL immediately.
//   Timeout counter width $clog2(TIMEOUT_CICLOS); increments only in ESPERA and saturates.
// CONFIGURATION
//   JOGO_TIMEOUT_EN defined: timeout counter, FIM_TIMEOUT and timeout output are present.
//   Undefined: no counter is synthesised; ESPERA waits indefinitely; timeout tied 0; code D unreachable.
// STRUCTURE
//   Package jogo_pkg: state code localparams (INICIAL..FIM_TIMEOUT, 4-bit) and function word(a, N).
//   Sub-module detector_jogada (chaves -> registered history + pulse).
//   FSM, counters and registers stay in this module.
// TESTING  (N_CHAVES=4, PROFUNDIDADE=4, TIMEOUT_CICLOS=20)
//   1. Assert reset mid-round in ESPERA -> same cycle: db_estado=0, db_contagem=0, all flags 0.
//   2. iniciar, then moves 0001,0010,0100,1000 (each held 3 cycles, 0000 between)
//      -> acertou=1, pronto=1, db_estado=A, db_contagem=3.
//   3. Moves 0001 then 0100 -> errou=1, pronto=1, db_estado=E, db_contagem=1,
//      db_memoria=0010, db_jogada=0100.
//   4. Macro on: no move for 20 cycles in ESPERA -> timeout=1, db_estado=D.
//      Macro off: still db_estado=2 after 100 cycles.
//   5. Hold chaves=0001 for 10 cycles -> exactly one db_tem_jogada pulse, db_contagem advances by 1.
//   6. From FIM_ACERTO, pulse iniciar -> PREPARACAO then ESPERA; acertou=0, pronto=0, db_contagem=0, leds=0.

Source files
------------

// File: rtl/jogo_memoria_param_pkg.sv
// Shared state codes and sequence ROM for the memory-game core.
package jogo_pkg;

  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARACAO  = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] REGISTRA    = 4'h4;
  localparam logic [3:0] COMPARA     = 4'h5;
  localparam logic [3:0] PROXIMO     = 4'h6;
  localparam logic [3:0] FIM_ACERTO  = 4'hA;
  localparam logic [3:0] FIM_TIMEOUT = 4'hD;
  localparam logic [3:0] FIM_ERRO    = 4'hE;

  // Sequence word for address a: a one-hot walk across the n switches.
  function automatic logic [31:0] word(input int a, input int n);
    return 32'd1 << (a % n);
  endfunction

endpackage

// File: rtl/jogo_memoria_param_if.sv
// Player-facing and debug signals of the memory-game core.
interface jogo_memoria_param_if #(
  parameter int N_CHAVES = 4,
  parameter int ADDR_W   = 4
);
  logic                iniciar;
  logic [N_CHAVES-1:0] chaves;
  logic                acertou;
  logic                errou;
  logic                timeout;
  logic                pronto;
  logic [N_CHAVES-1:0] leds;
  logic                db_igual;
  logic                db_tem_jogada;
  logic [ADDR_W-1:0]   db_contagem;
  logic [N_CHAVES-1:0] db_memoria;
  logic [N_CHAVES-1:0] db_jogada;
  logic [3:0]          db_estado;

  modport master (
    output iniciar, chaves,
    input  acertou, errou, timeout, pronto, leds, db_igual, db_tem_jogada,
           db_contagem, db_memoria, db_jogada, db_estado
  );

  modport slave (
    input  iniciar, chaves,
    output acertou, errou, timeout, pronto, leds, db_igual, db_tem_jogada,
           db_contagem, db_memoria, db_jogada, db_estado
  );
endinterface

// File: rtl/jogo_memoria_param_detector.sv
// Move detector: one pulse on each all-zero -> nonzero switch transition.
module detector_jogada #(
  parameter int N_CHAVES = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [N_CHAVES-1:0] i_chaves,
  output logic                o_tem_jogada
);
  logic [N_CHAVES-1:0] r_chaves_ant;

  // Switch history, one cycle behind the live inputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_chaves_ant <= '0;
    else         r_chaves_ant <= i_chaves;
  end

  assign o_tem_jogada = (i_chaves != '0) && (r_chaves_ant == '0);
endmodule

// File: rtl/jogo_memoria_param.sv
// Memory-game core: FSM, address/move registers and optional move timer.
// Optional feature macro: JOGO_TIMEOUT_EN (move timer + FIM_TIMEOUT state).
//
// state       | meaning
// INICIAL     | idle after reset, waits for iniciar
// PREPARACAO  | clears address, move register and timer
// ESPERA      | waits for a move (or timer expiry)
// REGISTRA    | latches the move
// COMPARA     | checks the move against the sequence word
// PROXIMO     | advances the address
// FIM_ACERTO  | whole sequence matched
// FIM_ERRO    | wrong move
// FIM_TIMEOUT | no move in time
module jogo_memoria_param
  import jogo_pkg::*;
#(
  parameter int N_CHAVES       = 4,
  parameter int PROFUNDIDADE   = 16,
  parameter int TIMEOUT_CICLOS = 5000
) (
  input logic          i_clock,
  input logic          i_reset,
  jogo_memoria_param_if.slave bus
);
  localparam int ADDR_W = $clog2(PROFUNDIDADE);

  logic [3:0]          r_estado;
  logic [3:0]          w_proximo;
  logic [ADDR_W-1:0]   r_endereco;
  logic [N_CHAVES-1:0] r_jogada;
  logic [N_CHAVES-1:0] w_memoria;
  logic                w_igual;
  logic                w_tem_jogada;
  logic                w_fim_tempo;
  logic                w_ultimo;

  detector_jogada #(.N_CHAVES(N_CHAVES)) u_detector (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_chaves     (bus.chaves),
    .o_tem_jogada (w_tem_jogada)
  );

  assign w_memoria = N_CHAVES'(word(32'(r_endereco), N_CHAVES));
  assign w_igual   = (r_jogada == w_memoria);
  assign w_ultimo  = (r_endereco == ADDR_W'(PROFUNDIDADE - 1));

`ifdef JOGO_TIMEOUT_EN
  localparam int TEMPO_W = $clog2(TIMEOUT_CICLOS);
  logic [TEMPO_W-1:0] r_tempo;

  // Move timer: counts only while waiting, saturates, cleared per move.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                                          r_tempo <= '0;
    else if (r_estado == PREPARACAO || r_estado == PROXIMO) r_tempo <= '0;
    else if (r_estado == ESPERA && r_tempo != '1)         r_tempo <= r_tempo + 1'b1;
  end

  assign w_fim_tempo = (r_tempo == TEMPO_W'(TIMEOUT_CICLOS - 1));
`else
  assign w_fim_tempo = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_estado <= INICIAL;
    else         r_estado <= w_proximo;
  end

  // Next-state logic; a move wins over a simultaneous timer expiry.
  always_comb begin
    w_proximo = r_estado;
    case (r_estado)
      INICIAL:     if (bus.iniciar) w_proximo = PREPARACAO;
      PREPARACAO:  w_proximo = ESPERA;
      ESPERA: begin
        if (w_tem_jogada)     w_proximo = REGISTRA;
        else if (w_fim_tempo) w_proximo = FIM_TIMEOUT;
      end
      REGISTRA:    w_proximo = COMPARA;
      COMPARA: begin
        if (!w_igual)      w_proximo = FIM_ERRO;
        else if (w_ultimo) w_proximo = FIM_ACERTO;
        else               w_proximo = PROXIMO;
      end
      PROXIMO:     w_proximo = ESPERA;
      FIM_ACERTO,
      FIM_ERRO,
      FIM_TIMEOUT: if (bus.iniciar) w_proximo = PREPARACAO;
      default:     w_proximo = INICIAL;
    endcase
  end

  // Address and move registers, driven by the current state.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_endereco <= '0;
      r_jogada   <= '0;
    end else begin
      case (r_estado)
        PREPARACAO: begin
          r_endereco <= '0;
          r_jogada   <= '0;
        end
        REGISTRA: r_jogada   <= bus.chaves;
        PROXIMO:  r_endereco <= r_endereco + 1'b1;
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the state register.
  always_comb begin
    bus.acertou = (r_estado == FIM_ACERTO);
    bus.errou   = (r_estado == FIM_ERRO);
`ifdef JOGO_TIMEOUT_EN
    bus.timeout = (r_estado == FIM_TIMEOUT);
`else
    bus.timeout = 1'b0;
`endif
    bus.pronto  = bus.acertou || bus.errou || bus.timeout;
  end

  assign bus.leds          = r_jogada;
  assign bus.db_jogada     = r_jogada;
  assign bus.db_igual      = w_igual;
  assign bus.db_tem_jogada = w_tem_jogada;
  assign bus.db_contagem   = r_endereco;
  assign bus.db_memoria    = w_memoria;
  assign bus.db_estado     = r_estado;
endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for the memory-game core (N_CHAVES=4, PROFUNDIDADE=4, TIMEOUT_CICLOS=20).
module tb_jogo_memoria_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jogo_memoria_param_if #(.N_CHAVES(4), .ADDR_W(2)) bus ();

  jogo_memoria_param #(
    .N_CHAVES(4), .PROFUNDIDADE(4), .TIMEOUT_CICLOS(20)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic logic [3:0] word_m(input int a);
    logic [31:0] w;
    w = 32'd1 << (a % 4);
    return w[3:0];
  endfunction

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty: observed %0h, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic start_round();
    @(negedge clk) bus.iniciar = 1'b1;
    @(negedge clk) bus.iniciar = 1'b0;
    @(negedge clk);
  endtask

  task automatic move(input logic [3:0] v);
    bus.chaves = v;
    repeat (3) @(negedge clk);
    bus.chaves = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Reset state
    rst = 1'b1;
    bus.iniciar = 1'b0;
    bus.chaves  = 4'b0000;
    push("rst_estado", 32'h0);
    push("rst_contagem", 32'h0);
    push("rst_pronto", 32'h0);
    push("rst_leds", 32'h0);
    push("rst_memoria", 32'(word_m(0)));
    push("rst_igual", 32'h0);
    push("rst_timeout", 32'h0);
    #1;
    chk(32'(bus.db_estado));
    chk(32'(bus.db_contagem));
    chk(32'(bus.pronto));
    chk(32'(bus.leds));
    chk(32'(bus.db_memoria));
    chk(32'(bus.db_igual));
    chk(32'(bus.timeout));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Full correct round
    start_round();
    push("t2_estado_espera", 32'(4'h2));
    chk(32'(bus.db_estado));
    push("t2_estado", 32'(4'hA));
    push("t2_acertou", 32'h1);
    push("t2_pronto", 32'h1);
    push("t2_errou", 32'h0);
    push("t2_contagem", 32'h3);
    push("t2_leds", 32'(word_m(3)));
    for (int i = 0; i < 4; i++) move(word_m(i));
    chk(32'(bus.db_estado));
    chk(32'(bus.acertou));
    chk(32'(bus.pronto));
    chk(32'(bus.errou));
    chk(32'(bus.db_contagem));
    chk(32'(bus.leds));

    // Restart from FIM_ACERTO
    push("t6_prep", 32'(4'h1));
    push("t6_espera", 32'(4'h2));
    push("t6_acertou", 32'h0);
    push("t6_pronto", 32'h0);
    push("t6_contagem", 32'h0);
    push("t6_leds", 32'h0);
    @(negedge clk) bus.iniciar = 1'b1;
    @(negedge clk) bus.iniciar = 1'b0;
    chk(32'(bus.db_estado));
    @(negedge clk);
    chk(32'(bus.db_estado));
    chk(32'(bus.acertou));
    chk(32'(bus.pronto));
    chk(32'(bus.db_contagem));
    chk(32'(bus.leds));

    // Wrong second move
    push("t3_estado", 32'(4'hE));
    push("t3_errou", 32'h1);
    push("t3_pronto", 32'h1);
    push("t3_acertou", 32'h0);
    push("t3_contagem", 32'h1);
    push("t3_memoria", 32'(word_m(1)));
    push("t3_jogada", 32'(4'b0100));
    push("t3_igual", 32'h0);
    move(4'b0001);
    move(4'b0100);
    chk(32'(bus.db_estado));
    chk(32'(bus.errou));
    chk(32'(bus.pronto));
    chk(32'(bus.acertou));
    chk(32'(bus.db_contagem));
    chk(32'(bus.db_memoria));
    chk(32'(bus.db_jogada));
    chk(32'(bus.db_igual));

    // Held switch gives one pulse; check pipeline latency on the way
    start_round();
    push("t5_registra", 32'(4'h4));
    push("t5_compara", 32'(4'h5));
    push("t5_proximo", 32'(4'h6));
    push("t5_espera", 32'(4'h2));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      if (i == 0) bus.chaves = 4'b0001;
      #1;
      if (bus.db_tem_jogada) pulses++;
      if (i >= 1 && i <= 4) chk(32'(bus.db_estado));
    end
    @(negedge clk) bus.chaves = 4'b0000;
    push("t5_pulses", 32'd1);
    push("t5_contagem", 32'h1);
    push("t5_estado", 32'(4'h2));
    @(negedge clk);
    chk(32'(pulses));
    chk(32'(bus.db_contagem));
    chk(32'(bus.db_estado));

    // Reset mid-round while waiting at address 1
    push("t1_estado", 32'h0);
    push("t1_contagem", 32'h0);
    push("t1_pronto", 32'h0);
    push("t1_errou", 32'h0);
    push("t1_acertou", 32'h0);
    push("t1_leds", 32'h0);
    rst = 1'b1;
    #1;
    chk(32'(bus.db_estado));
    chk(32'(bus.db_contagem));
    chk(32'(bus.pronto));
    chk(32'(bus.errou));
    chk(32'(bus.acertou));
    chk(32'(bus.leds));
    @(negedge clk) rst = 1'b0;

    // Timeout behaviour
    start_round();
`ifdef JOGO_TIMEOUT_EN
    push("t4_before", 32'(4'h2));
    push("t4_estado", 32'(4'hD));
    push("t4_timeout", 32'h1);
    push("t4_pronto", 32'h1);
    push("t4_restart", 32'(4'h1));
    repeat (19) @(negedge clk);
    chk(32'(bus.db_estado));
    @(negedge clk);
    chk(32'(bus.db_estado));
    chk(32'(bus.timeout));
    chk(32'(bus.pronto));
    bus.iniciar = 1'b1;
    @(negedge clk) bus.iniciar = 1'b0;
    chk(32'(bus.db_estado));
`else
    push("t4_estado", 32'(4'h2));
    push("t4_timeout", 32'h0);
    push("t4_pronto", 32'h0);
    repeat (100) @(negedge clk);
    chk(32'(bus.db_estado));
    chk(32'(bus.timeout));
    chk(32'(bus.pronto));
`endif

    if (sb.size() != 0) begin
      n_err++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
